// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        DISCARD = 2'd2
    } state_e;

    localparam logic [1:0] HZ_NONE     = 2'b00;
    localparam logic [1:0] HZ_LOAD_USE = 2'b11;

    // One bundle of every per-stage strobe the sequencer drives.
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exmem_stall;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
        logic pc_sel;
    } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones.
// Latency: count reflects increments from previous cycles (registered).
// Backpressure: none; inc_i is sampled every cycle.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use, branch redirect and bus-busy into stage strobes.
// Latency: strobes and PC redirect are combinational (zero cycle); state/counters registered.
// Backpressure: mem_busy_i freezes PC..EX/MEM; if_busy_i stalls PC and bubbles IF/ID.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            hazard_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  if_busy_i,
    input  logic                  mem_busy_i,
    output logic                  pc_stall_o,
    output logic                  ifid_stall_o,
    output logic                  idex_stall_o,
    output logic                  exmem_stall_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  memwb_flush_o,
    output logic                  pc_sel_o,
    output logic [ADDR_WIDTH-1:0] pc_target_o,
    output logic [DATA_WIDTH-1:0] stall_cycles_o,
    output logic [DATA_WIDTH-1:0] redirect_count_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
    ctrl_t                 ctrl;
    logic [ADDR_WIDTH-1:0] target;
    logic                  redirect_inc;

    always_comb begin
        ctrl          = '0;
        target        = branch_target_i;
        state_d       = state_q;
        pend_target_d = pend_target_q;
        unique case (state_q)
            BOOT: begin
                ctrl.pc_sel      = 1'b1;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
                ctrl.memwb_flush = 1'b1;
                target           = PC_ADDR;
                state_d          = RUN;
            end
            RUN: begin
                // EX is frozen under mem_busy_i, so a branch there is re-presented later.
                if (mem_busy_i) begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.ifid_stall  = 1'b1;
                    ctrl.idex_stall  = 1'b1;
                    ctrl.exmem_stall = 1'b1;
                    ctrl.memwb_flush = 1'b1;
                end else if (branch_taken_i && !if_busy_i) begin
                    ctrl.pc_sel     = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (branch_taken_i) begin
                    ctrl.pc_stall   = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    pend_target_d   = branch_target_i;
                    state_d         = DISCARD;
                end else if (hazard_i == HZ_LOAD_USE) begin
                    ctrl.pc_stall   = 1'b1;
                    ctrl.ifid_stall = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (if_busy_i) begin
                    ctrl.pc_stall   = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                end
            end
            DISCARD: begin
                target = pend_target_q;
                if (mem_busy_i) begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.ifid_stall  = 1'b1;
                    ctrl.idex_stall  = 1'b1;
                    ctrl.exmem_stall = 1'b1;
                    ctrl.memwb_flush = 1'b1;
                end else if (if_busy_i) begin
                    ctrl.pc_stall   = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                end else begin
                    // The completing fetch is the wrong-path word; drop it and redirect.
                    ctrl.ifid_flush = 1'b1;
                    ctrl.pc_sel     = 1'b1;
                    state_d         = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BOOT;
            pend_target_q <= PC_ADDR;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc_stall_o    = ctrl.pc_stall;
    assign ifid_stall_o  = ctrl.ifid_stall;
    assign idex_stall_o  = ctrl.idex_stall;
    assign exmem_stall_o = ctrl.exmem_stall;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_flush_o  = ctrl.idex_flush;
    assign memwb_flush_o = ctrl.memwb_flush;
    assign pc_sel_o      = ctrl.pc_sel;
    assign pc_target_o   = target;

    assign redirect_inc = ctrl.pc_sel && (state_q != BOOT);

    sat_counter #(.WIDTH(DATA_WIDTH)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (ctrl.pc_stall),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.WIDTH(DATA_WIDTH)) u_redirect_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (redirect_inc),
        .count_o (redirect_count_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes per-cycle expectations, monitor pops at negedge.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_pipeline_ctrl;

    localparam logic [31:0] PC0 = 32'h8000_0000;

    // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, memwb_flush, pc_sel}
    localparam logic [7:0] S_BOOT = 8'b0000_1111;
    localparam logic [7:0] S_IDLE = 8'b0000_0000;
    localparam logic [7:0] S_LU   = 8'b1100_0100;
    localparam logic [7:0] S_BR   = 8'b0000_1101;
    localparam logic [7:0] S_BRB  = 8'b1000_1100;
    localparam logic [7:0] S_IFB  = 8'b1000_1000;
    localparam logic [7:0] S_MEMB = 8'b1111_0010;
    localparam logic [7:0] S_DREL = 8'b0000_1001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  hazard = 2'b00;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        if_busy = 1'b0;
    logic        mem_busy = 1'b0;

    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, memwb_flush, pc_sel;
    logic [31:0] pc_target, stall_cycles, redirect_count;

    logic        s_pc_stall, s_ifid_stall, s_idex_stall, s_exmem_stall;
    logic        s_ifid_flush, s_idex_flush, s_memwb_flush, s_pc_sel;
    logic [31:0] s_pc_target;
    logic [3:0]  s_stall_cycles, s_redirect_count;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .hazard_i         (hazard),
        .branch_taken_i   (br_taken),
        .branch_target_i  (br_target),
        .if_busy_i        (if_busy),
        .mem_busy_i       (mem_busy),
        .pc_stall_o       (pc_stall),
        .ifid_stall_o     (ifid_stall),
        .idex_stall_o     (idex_stall),
        .exmem_stall_o    (exmem_stall),
        .ifid_flush_o     (ifid_flush),
        .idex_flush_o     (idex_flush),
        .memwb_flush_o    (memwb_flush),
        .pc_sel_o         (pc_sel),
        .pc_target_o      (pc_target),
        .stall_cycles_o   (stall_cycles),
        .redirect_count_o (redirect_count)
    );

    pipeline_ctrl #(.DATA_WIDTH(4)) dut_sat (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .hazard_i         (hazard),
        .branch_taken_i   (br_taken),
        .branch_target_i  (br_target),
        .if_busy_i        (if_busy),
        .mem_busy_i       (mem_busy),
        .pc_stall_o       (s_pc_stall),
        .ifid_stall_o     (s_ifid_stall),
        .idex_stall_o     (s_idex_stall),
        .exmem_stall_o    (s_exmem_stall),
        .ifid_flush_o     (s_ifid_flush),
        .idex_flush_o     (s_idex_flush),
        .memwb_flush_o    (s_memwb_flush),
        .pc_sel_o         (s_pc_sel),
        .pc_target_o      (s_pc_target),
        .stall_cycles_o   (s_stall_cycles),
        .redirect_count_o (s_redirect_count)
    );

    typedef struct {
        string       name;
        logic [7:0]  strb;
        logic        chk_tgt;
        logic [31:0] tgt;
        int          stall;
        int          redir;
        int          sat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic step(input string name, input logic rst, input logic [1:0] hz,
                        input logic br, input logic [31:0] bt, input logic ifb,
                        input logic memb, input logic [7:0] strb, input logic chk_tgt,
                        input logic [31:0] tgt, input int sc, input int rc, input int sat);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        hazard    = hz;
        br_taken  = br;
        br_target = bt;
        if_busy   = ifb;
        mem_busy  = memb;
        e.name    = name;
        e.strb    = strb;
        e.chk_tgt = chk_tgt;
        e.tgt     = tgt;
        e.stall   = sc;
        e.redir   = rc;
        e.sat     = sat;
        q.push_back(e);
    endtask

    exp_t       m;
    logic [7:0] got;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m   = q.pop_front();
            got = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                   ifid_flush, idex_flush, memwb_flush, pc_sel};
            checks++;
            if (got !== m.strb) begin
                failures++;
                $display("FAIL %s strobes got=%b exp=%b", m.name, got, m.strb);
            end
            if (m.chk_tgt) begin
                checks++;
                if (pc_target !== m.tgt) begin
                    failures++;
                    $display("FAIL %s pc_target got=%h exp=%h", m.name, pc_target, m.tgt);
                end
            end
            if (m.stall >= 0) begin
                checks++;
                if (stall_cycles !== 32'(m.stall)) begin
                    failures++;
                    $display("FAIL %s stall_cycles got=%0d exp=%0d", m.name, stall_cycles, m.stall);
                end
            end
            if (m.redir >= 0) begin
                checks++;
                if (redirect_count !== 32'(m.redir)) begin
                    failures++;
                    $display("FAIL %s redirect_count got=%0d exp=%0d", m.name, redirect_count, m.redir);
                end
            end
            if (m.sat >= 0) begin
                checks++;
                if (s_stall_cycles !== 4'(m.sat)) begin
                    failures++;
                    $display("FAIL %s sat_stall_cycles got=%0d exp=%0d", m.name, s_stall_cycles, m.sat);
                end
            end
        end
    end

    initial begin
        //   name          rst hz     br   target        ifb   memb  strobes  chkT  target        S   R   sat
        step("rst0",       0, 2'b00, 0, 32'h0,         0,    0,    S_BOOT,  1, PC0,           0,  0,  0);
        step("rst1",       0, 2'b00, 0, 32'h0,         0,    0,    S_BOOT,  1, PC0,           0,  0, -1);
        step("boot",       1, 2'b00, 0, 32'h0,         0,    0,    S_BOOT,  1, PC0,           0,  0, -1);
        step("idle0",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,         0,  0, -1);
        step("loaduse",    1, 2'b11, 0, 32'h0,         0,    0,    S_LU,    0, 32'h0,        -1, -1, -1);
        step("idle1",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,         1,  0, -1);
        step("br_hz",      1, 2'b11, 1, 32'h8000_0040, 0,    0,    S_BR,    1, 32'h8000_0040,-1, -1, -1);
        step("idle2",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,         1,  1, -1);
        step("br_busy",    1, 2'b00, 1, 32'h8000_0100, 1,    0,    S_BRB,   1, 32'h8000_0100,-1, -1, -1);
        for (int i = 0; i < 3; i++)
            step("disc_busy", 1, 2'b11, 1, 32'h8000_0BAD, 1, 0,    S_IFB,   1, 32'h8000_0100,-1, -1, -1);
        step("disc_rel",   1, 2'b11, 1, 32'h8000_0BAD, 0,    0,    S_DREL,  1, 32'h8000_0100,-1, -1, -1);
        step("idle3",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,         5,  2, -1);
        step("if_busy",    1, 2'b00, 0, 32'h0000_0ABC, 1,    0,    S_IFB,   1, 32'h0000_0ABC,-1, -1, -1);
        step("idle4",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,         6,  2, -1);
        for (int i = 0; i < 4; i++)
            step("mem_busy",  1, 2'b11, 1, 32'h8000_0200, 0, 1,    S_MEMB,  0, 32'h0,        -1, -1, -1);
        step("mem_rel_br", 1, 2'b00, 1, 32'h8000_0200, 0,    0,    S_BR,    1, 32'h8000_0200,-1, -1, -1);
        step("idle5",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,        10,  3, -1);
        step("br_busy2",   1, 2'b00, 1, 32'h8000_0300, 1,    0,    S_BRB,   0, 32'h0,        -1, -1, -1);
        step("disc_mem_if",1, 2'b00, 0, 32'h0,         1,    1,    S_MEMB,  1, 32'h8000_0300,-1, -1, -1);
        step("disc_mem",   1, 2'b00, 0, 32'h0,         0,    1,    S_MEMB,  1, 32'h8000_0300,-1, -1, -1);
        step("disc_rel2",  1, 2'b00, 0, 32'h0,         0,    0,    S_DREL,  1, 32'h8000_0300,-1, -1, -1);
        step("idle6",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,        13,  4, 13);
        for (int i = 0; i < 20; i++)
            step("sat_busy",  1, 2'b00, 0, 32'h0,      1,    0,    S_IFB,   0, 32'h0,        -1, -1, -1);
        step("idle7",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,        33,  4, 15);
        step("br_busy3",   1, 2'b00, 1, 32'h8000_0400, 1,    0,    S_BRB,   0, 32'h0,        -1, -1, -1);
        step("disc_busy3", 1, 2'b00, 0, 32'h0,         1,    0,    S_IFB,   1, 32'h8000_0400,-1, -1, -1);
        step("rst_disc",   0, 2'b00, 0, 32'h0,         1,    0,    S_BOOT,  1, PC0,           0,  0,  0);
        step("boot2",      1, 2'b00, 0, 32'h0,         0,    0,    S_BOOT,  1, PC0,           0,  0,  0);
        step("idle8",      1, 2'b00, 0, 32'h0,         0,    0,    S_IDLE,  0, 32'h0,         0,  0,  0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. Merges the hazard detector's load-use request, the EX-stage branch redirect, and the IF/MEM bus-busy indications into per-stage stall/flush strobes and the PC redirect. It also owns the wrong-path-fetch discard sequence and two saturating performance counters. It sits between the hazard detector, the bus masters and the pipeline registers.

## Interface
- PC_ADDR, 32'h8000_0000, boot PC issued as the first redirect after reset
- ADDR_WIDTH, 32, PC/target width
- DATA_WIDTH, 32, performance counter width
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- hazard_i  in  2  hazard detector output: bit0 = stall IF/ID, bit1 = bubble ID/EX; 2'b11 = load-use, 2'b00 = none, 01/10 illegal
- branch_taken_i  in  1  EX resolved a taken branch/jump this cycle
- branch_target_i  in  ADDR_WIDTH  redirect target, valid with branch_taken_i
- if_busy_i  in  1  instruction fetch not complete this cycle
- mem_busy_i  in  1  MEM-stage data access not complete this cycle
- pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o  out  1 each  hold register
- ifid_flush_o, idex_flush_o, memwb_flush_o  out  1 each  load bubble
- pc_sel_o  out  1  PC loads pc_target_o at this edge
- pc_target_o  out  ADDR_WIDTH  redirect address
- stall_cycles_o  out  DATA_WIDTH  cycles with pc_stall_o=1, saturating
- redirect_count_o  out  DATA_WIDTH  redirects issued (boot excluded), saturating

## Operation
- FSM states: BOOT, RUN, DISCARD. Reset state BOOT.
- BOOT (exactly one cycle after rst_ni rises): pc_sel_o=1, pc_target_o=PC_ADDR, ifid_flush_o=idex_flush_o=memwb_flush_o=1 -> RUN.
- RUN, priority high to low:
  1. mem_busy_i: assert pc/ifid/idex/exmem stall and memwb_flush. Branch and hazard inputs are ignored, because EX is frozen and re-presents the branch later.
  2. branch_taken_i && !if_busy_i: pc_sel_o=1, pc_target_o=branch_target_i, ifid_flush_o=idex_flush_o=1. Overrides a simultaneous load-use.
  3. branch_taken_i && if_busy_i: latch branch_target_i into pend_target, idex_flush_o=1, ifid_flush_o=1, pc_stall_o=1 -> DISCARD.
  4. hazard_i==2'b11: pc_stall_o=ifid_stall_o=1, idex_flush_o=1. If if_busy_i is also set, the outputs are the same.
  5. if_busy_i: pc_stall_o=1, ifid_flush_o=1; downstream advances.
  6. Otherwise all strobes are 0.
- DISCARD: waits for the wrong-path fetch already on the bus to complete; hazard_i and branch_taken_i are ignored (ID/EX hold bubbles).
  - mem_busy_i: same freeze as RUN rule 1, stay.
  - if_busy_i && !mem_busy_i: pc_stall_o=1, ifid_flush_o=1, stay.
  - !if_busy_i && !mem_busy_i: ifid_flush_o=1 (drop wrong-path word), pc_sel_o=1, pc_target_o=pend_target -> RUN.
- Outside a redirect, pc_target_o equals pend_target in DISCARD and branch_target_i in RUN. It is a don't-care when pc_sel_o=0 but must not be X.
- Counters: +1 per cycle for the qualifying strobe; hold at all-ones.

## Timing
- All strobes are combinational from state and inputs (zero-cycle latency), and pipeline registers act at the next rising edge.
- State, pend_target and counters are registered.
- While rst_ni is low, asynchronously:
  - state=BOOT and pend_target=PC_ADDR;
  - counters are 0;
  - outputs take BOOT values: pc_sel_o=1, pc_target_o=PC_ADDR, three flushes 1, all stalls 0.
- Reset mid-DISCARD abandons pend_target; the post-reset BOOT redirect wins.
- A stall strobe and a flush strobe are never both asserted on the same register.
- Branch latency: a redirect with if_busy_i low takes one cycle. With if_busy_i high it takes N+1 cycles, where N is the remaining busy cycles.

## Structure
- Package pipeline_ctrl_pkg: state enum (BOOT/RUN/DISCARD) and the hazard_i encoding constants HZ_NONE and HZ_LOAD_USE.
- Sub-module sat_counter (parameter WIDTH; inputs inc and the async active-low reset): instantiated twice for the counters.

## Test plan
- Reset release: first cycle pc_sel_o=1, pc_target_o=32'h8000_0000, then all strobes 0 with idle inputs; counters 0.
- Load-use: hazard_i=2'b11 for 1 cycle -> pc_stall_o=ifid_stall_o=idex_flush_o=1 that cycle; stall_cycles_o=1 afterwards.
- Branch with idle IF: branch_taken_i=1 with target 32'h8000_0040 -> same-cycle pc_sel_o=1, pc_target_o=32'h8000_0040, ifid/idex flush; redirect_count_o=1. A simultaneous hazard_i=2'b11 is ignored.
- Branch with IF busy 3 more cycles: target 32'h8000_0100 -> DISCARD. Busy cycles give pc_stall_o=1 and ifid_flush_o=1. The first non-busy cycle gives pc_sel_o=1 and pc_target_o=32'h8000_0100. The branch_target_i change during DISCARD has no effect.
- mem_busy_i high 4 cycles with branch_taken_i held -> pc/ifid/idex/exmem stall and memwb_flush for 4 cycles, no pc_sel_o. The redirect is issued on cycle 5.
- Saturation: force counter width 4 via DATA_WIDTH=4 and hold if_busy_i for 20 cycles -> stall_cycles_o sticks at 4'hF; reset asserted mid-DISCARD -> outputs take BOOT values immediately.
